// File: rtl/i2s_rx_deserializer_pkg.sv
// Shared definitions for the I2S receive deserializer.
// Holds the FSM state encoding and the bit counter width helper.
package i2s_rx_deserializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEEK  = 2'd1,
        ST_LEFT  = 2'd2,
        ST_RIGHT = 2'd3
    } state_t;

    // The counter must be able to hold data_width itself, where it saturates.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// Pin group and frame handshake of the I2S receive deserializer.
// audio_vd high means audio_data holds an unread frame; audio_re high while audio_vd is high pops it.
interface i2s_rx_deserializer_if #(
    parameter int data_width = 16
);
    logic                      bclk;
    logic                      lrclk;
    logic                      sdata;
    logic                      enable;
    logic [2*data_width-1:0]   audio_data;
    logic                      audio_vd;
    logic                      audio_re;
    logic                      overrun;
    logic                      overrun_clr;

    modport master (
        input  bclk, lrclk, sdata, enable, audio_re, overrun_clr,
        output audio_data, audio_vd, overrun
    );

    modport slave (
        output bclk, lrclk, sdata, enable, audio_re, overrun_clr,
        input  audio_data, audio_vd, overrun
    );
endinterface

// File: rtl/i2s_rx_pin_sync.sv
// Synchronizes the three I2S pins into the system clock domain and
// produces a registered single-cycle pulse on each BCLK rising edge.
module i2s_rx_pin_sync #(
    parameter int sync_stages = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bclk_pin,
    input  logic lrclk_pin,
    input  logic sdata_pin,
    output logic b_rise,
    output logic sd,
    output logic lr
);

    logic [sync_stages-1:0] bclk_s;
    logic [sync_stages-1:0] lr_s;
    logic [sync_stages-1:0] sd_s;
    logic                   bclk_d;

    // sd and lr are registered alongside b_rise so all three line up in time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_s <= '0;
            lr_s   <= '1;
            sd_s   <= '0;
            bclk_d <= 1'b0;
            b_rise <= 1'b0;
            sd     <= 1'b0;
            lr     <= 1'b1;
        end else begin
            bclk_s <= {bclk_s[sync_stages-2:0], bclk_pin};
            lr_s   <= {lr_s[sync_stages-2:0], lrclk_pin};
            sd_s   <= {sd_s[sync_stages-2:0], sdata_pin};
            bclk_d <= bclk_s[sync_stages-1];
            b_rise <= bclk_s[sync_stages-1] & ~bclk_d;
            sd     <= sd_s[sync_stages-1];
            lr     <= lr_s[sync_stages-1];
        end
    end

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S (Philips) slave receiver: aligns to the LR word clock, captures
// MSB-first left/right slots and presents them as one packed frame.
module i2s_rx_deserializer
    import i2s_rx_deserializer_pkg::*;
#(
    parameter int data_width  = 16,
    parameter int sync_stages = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    i2s_rx_deserializer_if.master  bus,
    output state_t                 state
);

    localparam int                 cnt_w   = cnt_width(data_width);
    localparam logic [cnt_w-1:0]   cnt_max = cnt_w'(data_width);

    logic                     b_rise;
    logic                     sd;
    logic                     lr;
    logic                     lr_prev;
    logic [cnt_w-1:0]         bit_cnt;
    logic [data_width-1:0]    slot_reg;
    logic [data_width-1:0]    slot_next;
    logic [data_width-1:0]    left_reg;
    logic [2*data_width-1:0]  data_q;
    logic                     vd_q;
    logic                     overrun_q;
    logic                     lr_fall;
    logic                     lr_rise;
    logic                     emit;

    i2s_rx_pin_sync #(
        .sync_stages (sync_stages)
    ) u_pin_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .bclk_pin  (bus.bclk),
        .lrclk_pin (bus.lrclk),
        .sdata_pin (bus.sdata),
        .b_rise    (b_rise),
        .sd        (sd),
        .lr        (lr)
    );

    // Slot contents including the current bit; the boundary bit still belongs to the old slot.
    always_comb begin
        slot_next = slot_reg;
        for (int i = 0; i < data_width; i++) begin
            if (b_rise && (bit_cnt < cnt_max) && (int'(bit_cnt) == data_width - 1 - i)) begin
                slot_next[i] = sd;
            end
        end
    end

    assign lr_fall = b_rise && !lr && lr_prev;
    assign lr_rise = b_rise && lr && !lr_prev;
    assign emit    = bus.enable && (state == ST_RIGHT) && lr_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lr_prev   <= 1'b1;
            bit_cnt   <= '0;
            slot_reg  <= '0;
            left_reg  <= '0;
            data_q    <= '0;
            vd_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // lr_prev tracks the word clock even while idle so SEEK never sees a stale edge.
            if (b_rise) begin
                lr_prev <= lr;
                if (lr != lr_prev) begin
                    bit_cnt  <= '0;
                    slot_reg <= '0;
                end else begin
                    slot_reg <= slot_next;
                    if (bit_cnt < cnt_max) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end

            if (!bus.enable) begin
                state    <= ST_IDLE;
                vd_q     <= 1'b0;
                slot_reg <= '0;
            end else begin
                case (state)
                    ST_IDLE:  state <= ST_SEEK;
                    ST_SEEK:  if (lr_fall) state <= ST_LEFT;
                    ST_LEFT: begin
                        if (lr_rise) begin
                            left_reg <= slot_next;
                            state    <= ST_RIGHT;
                        end
                    end
                    ST_RIGHT: if (lr_fall) state <= ST_LEFT;
                    default:  state <= ST_IDLE;
                endcase

                if (emit) begin
                    data_q <= {left_reg, slot_next};
                    vd_q   <= 1'b1;
                end else if (bus.audio_re) begin
                    vd_q <= 1'b0;
                end
            end

            // A new overrun in the same cycle as a clear must stay visible.
            if (emit && vd_q && !bus.audio_re) begin
                overrun_q <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.audio_data = data_q;
    assign bus.audio_vd   = vd_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Self-checking bench for i2s_rx_deserializer: drives Philips I2S frames
// at 16 clocks per BCLK and checks emitted frames against an expected queue.
`timescale 1ns/1ps
module tb_i2s_rx_deserializer;
    import i2s_rx_deserializer_pkg::*;

    localparam int data_width  = 16;
    localparam int sync_stages = 2;
    localparam int half_bclk   = 8;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t state;

    i2s_rx_deserializer_if #(.data_width(data_width)) bus();

    i2s_rx_deserializer #(
        .data_width  (data_width),
        .sync_stages (sync_stages)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .state (state)
    );

    // ---------------- clock / reset / monitors ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   vd_rise_cyc = 0;
    int   vd_rise_cnt = 0;
    logic vd_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.audio_vd === 1'b1 && vd_prev !== 1'b1) begin
            vd_rise_cyc <= cyc;
            vd_rise_cnt <= vd_rise_cnt + 1;
        end
        vd_prev <= bus.audio_vd;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    logic [31:0] exp_val;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          ok;
    int          cnt0;

    // ---------------- drivers ----------------
    logic pending = 1'b0;
    bit   closed = 1'b0;
    bit   read_on_rise = 1'b0;
    int   last_rise_cyc = 0;

    function automatic logic word_bit(input logic [15:0] w, input int dlen, input int k);
        if (k < dlen) return w[dlen-1-k];
        return 1'b0;
    endfunction

    // One BCLK period; sd lags lr by one bit, as on a Philips I2S bus.
    task automatic tx(input logic lr_val, input logic bit_val);
        @(negedge clk);
        bus.bclk  = 1'b0;
        bus.lrclk = lr_val;
        bus.sdata = pending;
        pending   = bit_val;
        repeat (half_bclk) @(negedge clk);
        bus.bclk = 1'b1;
        last_rise_cyc = cyc;
        for (int i = 1; i < half_bclk; i++) begin
            @(negedge clk);
            if (read_on_rise && i == sync_stages + 1) bus.audio_re = 1'b1;
            else if (read_on_rise && i == sync_stages + 2) bus.audio_re = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int dlen, input int slen);
        int k0;
        k0 = closed ? 1 : 0;
        if (closed) pending = word_bit(l, dlen, 0);
        closed = 1'b0;
        for (int k = k0; k < slen; k++) tx(1'b0, word_bit(l, dlen, k));
        for (int k = 0; k < slen; k++) tx(1'b1, word_bit(r, dlen, k));
    endtask

    // Drives the LR 1->0 edge that closes the last frame and starts a left slot.
    task automatic close_frame();
        tx(1'b0, 1'b0);
        closed = 1'b1;
    endtask

    task automatic do_read();
        @(negedge clk);
        bus.audio_re = 1'b1;
        @(negedge clk);
        bus.audio_re = 1'b0;
    endtask

    task automatic wait_vd(output bit got);
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.audio_vd === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_checks++; if (bus.audio_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", bus.audio_data); end
        n_checks++; if (bus.audio_vd !== 1'b0) begin n_fail++; $display("FAIL reset_vd: got %b, expected 0", bus.audio_vd); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, expected 0", bus.overrun); end
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, expected %0d", state, ST_IDLE); end
        bus.enable = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (state !== ST_SEEK) begin n_fail++; $display("FAIL enable_state: got %0d, expected %0d", state, ST_SEEK); end
        tx(1'b1, 1'b0);
        tx(1'b1, 1'b0);
    endtask

    task automatic test_basic();
        exp_q.push_back(32'hA5C31234);
        send_frame(16'hA5C3, 16'h1234, 16, 32);
        n_checks++; if (bus.audio_vd !== 1'b0) begin n_fail++; $display("FAIL basic_no_early_vd: got %b, expected 0", bus.audio_vd); end
        close_frame();
        wait_vd(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_vd_timeout: got %b, expected 1", bus.audio_vd); end
        n_checks++; if (vd_rise_cyc - last_rise_cyc !== sync_stages + 2) begin n_fail++; $display("FAIL basic_latency: got %0d, expected %0d", vd_rise_cyc - last_rise_cyc, sync_stages + 2); end
        exp_val = exp_q.pop_front();
        n_checks++; if (bus.audio_data !== exp_val) begin n_fail++; $display("FAIL basic_data: got %h, expected %h", bus.audio_data, exp_val); end
        do_read();
        n_checks++; if (bus.audio_vd !== 1'b0) begin n_fail++; $display("FAIL basic_read_clears_vd: got %b, expected 0", bus.audio_vd); end
    endtask

    task automatic test_short_slots();
        exp_q.push_back(32'hFFFF8001);
        send_frame(16'hFFFF, 16'h8001, 16, 16);
        close_frame();
        wait_vd(ok);
        exp_val = exp_q.pop_front();
        n_checks++; if (!ok || bus.audio_data !== exp_val) begin n_fail++; $display("FAIL short16_data: got %h vd=%b, expected %h", bus.audio_data, bus.audio_vd, exp_val); end
        do_read();
        exp_q.push_back(32'hABC01230);
        send_frame(16'h0ABC, 16'h0123, 12, 12);
        close_frame();
        wait_vd(ok);
        exp_val = exp_q.pop_front();
        n_checks++; if (!ok || bus.audio_data !== exp_val) begin n_fail++; $display("FAIL short12_data: got %h vd=%b, expected %h", bus.audio_data, bus.audio_vd, exp_val); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL short_overrun: got %b, expected 0", bus.overrun); end
        do_read();
    endtask

    task automatic test_overrun();
        exp_q.push_back(32'h11112222);
        exp_q.push_back(32'h33334444);
        send_frame(16'h1111, 16'h2222, 16, 32);
        send_frame(16'h3333, 16'h4444, 16, 32);
        exp_val = exp_q.pop_front();
        n_checks++; if (bus.audio_vd !== 1'b1 || bus.audio_data !== exp_val) begin n_fail++; $display("FAIL overrun_first: got %h vd=%b, expected %h", bus.audio_data, bus.audio_vd, exp_val); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_not_yet: got %b, expected 0", bus.overrun); end
        close_frame();
        exp_val = exp_q.pop_front();
        n_checks++; if (bus.audio_data !== exp_val) begin n_fail++; $display("FAIL overrun_data: got %h, expected %h", bus.audio_data, exp_val); end
        n_checks++; if (bus.overrun !== 1'b1 || bus.audio_vd !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got ovr=%b vd=%b, expected 1 1", bus.overrun, bus.audio_vd); end
        @(negedge clk); bus.overrun_clr = 1'b1;
        @(negedge clk); bus.overrun_clr = 1'b0;
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b, expected 0", bus.overrun); end
        do_read();
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(32'h55556666);
        exp_q.push_back(32'h77778888);
        send_frame(16'h5555, 16'h6666, 16, 32);
        send_frame(16'h7777, 16'h8888, 16, 32);
        exp_val = exp_q.pop_front();
        n_checks++; if (bus.audio_vd !== 1'b1 || bus.audio_data !== exp_val) begin n_fail++; $display("FAIL b2b_first: got %h vd=%b, expected %h", bus.audio_data, bus.audio_vd, exp_val); end
        read_on_rise = 1'b1;
        close_frame();
        read_on_rise = 1'b0;
        exp_val = exp_q.pop_front();
        n_checks++; if (bus.audio_data !== exp_val) begin n_fail++; $display("FAIL b2b_data: got %h, expected %h", bus.audio_data, exp_val); end
        n_checks++; if (bus.audio_vd !== 1'b1) begin n_fail++; $display("FAIL b2b_vd_held: got %b, expected 1", bus.audio_vd); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun: got %b, expected 0", bus.overrun); end
        do_read();
    endtask

    task automatic test_mid_frame_start();
        bus.enable = 1'b0;
        send_frame(16'hDEAD, 16'hBEEF, 16, 32);
        close_frame();
        bus.enable = 1'b1;
        cnt0 = vd_rise_cnt;
        send_frame(16'hCAFE, 16'hF00D, 16, 32);
        n_checks++; if (bus.audio_vd !== 1'b0) begin n_fail++; $display("FAIL midstart_partial: got vd=%b, expected 0", bus.audio_vd); end
        exp_q.push_back(32'h0F0FF0F0);
        send_frame(16'h0F0F, 16'hF0F0, 16, 32);
        close_frame();
        wait_vd(ok);
        exp_val = exp_q.pop_front();
        n_checks++; if (!ok || bus.audio_data !== exp_val) begin n_fail++; $display("FAIL midstart_data: got %h vd=%b, expected %h", bus.audio_data, bus.audio_vd, exp_val); end
        n_checks++; if (vd_rise_cnt - cnt0 !== 1) begin n_fail++; $display("FAIL midstart_count: got %0d frames, expected 1", vd_rise_cnt - cnt0); end
        do_read();
    endtask

    task automatic test_enable_drop();
        exp_q.push_back(32'h12345678);
        send_frame(16'h1234, 16'h5678, 16, 32);
        send_frame(16'hAAAA, 16'hBBBB, 16, 32);
        exp_val = exp_q.pop_front();
        n_checks++; if (bus.audio_vd !== 1'b1 || bus.audio_data !== exp_val) begin n_fail++; $display("FAIL drop_pre: got %h vd=%b, expected %h", bus.audio_data, bus.audio_vd, exp_val); end
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.audio_vd !== 1'b0) begin n_fail++; $display("FAIL drop_vd: got %b, expected 0", bus.audio_vd); end
        n_checks++; if (bus.audio_data !== 32'h12345678) begin n_fail++; $display("FAIL drop_data_held: got %h, expected 12345678", bus.audio_data); end
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL drop_state: got %0d, expected %0d", state, ST_IDLE); end
        bus.enable = 1'b1;
        cnt0 = vd_rise_cnt;
        close_frame();
        n_checks++; if (bus.audio_vd !== 1'b0 || vd_rise_cnt !== cnt0) begin n_fail++; $display("FAIL drop_no_emit: got vd=%b frames=%0d, expected 0 0", bus.audio_vd, vd_rise_cnt - cnt0); end
        exp_q.push_back(32'h01020304);
        send_frame(16'h0102, 16'h0304, 16, 32);
        close_frame();
        wait_vd(ok);
        exp_val = exp_q.pop_front();
        n_checks++; if (!ok || bus.audio_data !== exp_val) begin n_fail++; $display("FAIL drop_recover: got %h vd=%b, expected %h", bus.audio_data, bus.audio_vd, exp_val); end
        do_read();
    endtask

    task automatic test_reset_mid();
        send_frame(16'h0001, 16'h0002, 16, 32);
        send_frame(16'h0003, 16'h0004, 16, 32);
        send_frame(16'h0005, 16'h0006, 16, 32);
        n_checks++; if (bus.overrun !== 1'b1 || bus.audio_vd !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got ovr=%b vd=%b, expected 1 1", bus.overrun, bus.audio_vd); end
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.audio_data !== 32'h0 || bus.audio_vd !== 1'b0 || bus.overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got %h vd=%b ovr=%b, expected 0 0 0", bus.audio_data, bus.audio_vd, bus.overrun); end
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d, expected %0d", state, ST_IDLE); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- sequence ----------------
    initial begin
        bus.bclk        = 1'b0;
        bus.lrclk       = 1'b1;
        bus.sdata       = 1'b0;
        bus.enable      = 1'b0;
        bus.audio_re    = 1'b0;
        bus.overrun_clr = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_basic();
        test_short_slots();
        test_overrun();
        test_back_to_back();
        test_mid_frame_start();
        test_enable_drop();
        test_reset_mid();

        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
